// File: rtl/sha256_mining_ctrl.sv
// sha256_mining_ctrl
//   Mining sequencer and bus master for a register-mapped SHA-256 core.
//   For each nonce in an inclusive range it hashes the padded 80-byte header
//   twice (SHA256d), byte-reverses the final digest and compares it against a
//   256-bit target. The run stops on the first hit or after the last nonce.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start               1-cycle pulse, accepted only when idle
//   header_in[639:0]    block header; [31:0] is replaced by the nonce under test
//   nonce_start/_end    inclusive nonce range
//   target[255:0]       hit when reversed digest < target
//   busy, done, found   run status; done/found held until the next accepted start
//   nonce_out, hash_out hit nonce (or last nonce tested) and its reversed digest
//   sha_*               single-cycle register accesses to the SHA-256 core
module sha256_mining_ctrl #(
    parameter int POLL_GAP = 1  // idle cycles between a CTRL write and the first poll (1..256)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [639:0] header_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [255:0] hash_out,
    output logic         sha_cs,
    output logic         sha_we,
    output logic [7:0]   sha_address,
    output logic [31:0]  sha_write_data,
    input  logic [31:0]  sha_read_data
);

    typedef enum logic [3:0] {
        IDLE, WR_BLK, WR_CTRL, GAP, POLL, RD_DIG, CMP, NEXT, FIN
    } state_t;

    // H1A: header block 1 (init), H1B: header block 2 (next), H2: digest block (init)
    typedef enum logic [1:0] {H1A, H1B, H2} phase_t;

    localparam logic [7:0]  ADDR_CTRL   = 8'h08;
    localparam logic [7:0]  ADDR_STATUS = 8'h09;
    localparam logic [7:0]  ADDR_BLOCK  = 8'h10;
    localparam logic [7:0]  ADDR_DIGEST = 8'h20;
    localparam logic [31:0] CMD_INIT    = 32'h0000_0005;
    localparam logic [31:0] CMD_NEXT    = 32'h0000_0006;
    localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 1);

    state_t         state, state_n;
    phase_t         phase;
    logic [607:0]   hdr_hi;      // header_in[639:32]
    logic [31:0]    nonce;
    logic [31:0]    nonce_last;
    logic [255:0]   tgt;
    logic [255:0]   dig;         // d1 after H1B reads, d2 after H2 reads
    logic [255:0]   rev;
    logic [639:0]   h;
    logic [511:0]   blk;
    logic [31:0]    blk_word;
    logic [3:0]     wcnt;
    logic [2:0]     rcnt;
    logic [7:0]     gcnt;
    logic           hit;
    logic           rev_lt;
    logic           unused;

    // The header's own nonce field is always overwritten by the nonce under test.
    assign unused = ^header_in[31:0];

    assign h = {hdr_hi, nonce};

    always_comb begin
        case (phase)
            H1A:     blk = h[639:128];
            H1B:     blk = {h[127:0], 1'b1, 319'b0, 64'h280};
            default: blk = {dig, 1'b1, 191'b0, 64'h100};
        endcase
    end

    // Word 0 (first written) is the most significant word of the block.
    assign blk_word = blk[32*(15 - int'(wcnt)) +: 32];

    // Byte 0 of the digest becomes byte 31 of the compared value and vice versa.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rev[8*i +: 8] = dig[8*(31 - i) +: 8];
        end
    end

    assign rev_lt = rev < tgt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n        = state;
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = 8'h00;
        sha_write_data = 32'h0;
        case (state)
            IDLE: if (start) state_n = WR_BLK;
            WR_BLK: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = ADDR_BLOCK + {4'd0, wcnt};
                sha_write_data = blk_word;
                if (wcnt == 4'd15) state_n = WR_CTRL;
            end
            WR_CTRL: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = ADDR_CTRL;
                sha_write_data = (phase == H1B) ? CMD_NEXT : CMD_INIT;
                state_n        = GAP;
            end
            GAP: if (gcnt == GAP_LAST) state_n = POLL;
            POLL: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_STATUS;
                if (sha_read_data[0]) state_n = (phase == H1A) ? WR_BLK : RD_DIG;
            end
            RD_DIG: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_DIGEST + {5'd0, rcnt};
                if (rcnt == 3'd7) state_n = (phase == H1B) ? WR_BLK : CMP;
            end
            CMP:     state_n = (rev_lt || nonce == nonce_last) ? FIN : NEXT;
            NEXT:    state_n = WR_BLK;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control counters and visible outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase     <= H1A;
            wcnt      <= 4'd0;
            rcnt      <= 3'd0;
            gcnt      <= 8'd0;
            hit       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            nonce_out <= 32'h0;
            hash_out  <= 256'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    found     <= 1'b0;
                    nonce_out <= 32'h0;
                    hash_out  <= 256'h0;
                    phase     <= H1A;
                    wcnt      <= 4'd0;
                    rcnt      <= 3'd0;
                end
                WR_BLK:  wcnt <= wcnt + 4'd1;   // wraps to 0 after word 15
                WR_CTRL: gcnt <= 8'd0;
                GAP:     gcnt <= gcnt + 8'd1;
                POLL:    if (sha_read_data[0] && phase == H1A) phase <= H1B;
                RD_DIG: begin
                    rcnt <= rcnt + 3'd1;       // wraps to 0 after word 7
                    if (rcnt == 3'd7 && phase == H1B) phase <= H2;
                end
                CMP:  hit   <= rev_lt;
                NEXT: phase <= H1A;
                FIN: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    found     <= hit;
                    nonce_out <= nonce;
                    hash_out  <= rev;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the wide datapath registers carry no reset; each is loaded before
    // it is ever used, so resetting them would only add fanout on reset_n.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                hdr_hi     <= header_in[639:32];
                nonce      <= nonce_start;
                nonce_last <= nonce_end;
                tgt        <= target;
            end
            RD_DIG:  dig   <= {dig[223:0], sha_read_data};
            NEXT:    nonce <= nonce + 32'd1;
            default: ;
        endcase
    end

endmodule
